ac_upsp_stream: RTL
===================

AC_UPSP_STREAM -- requirements
Module: ac_upsp_stream

Interface
REQ-001 SHALL have parameter CRF_DATA_WIDTH, default 32, the width of the control registers UPSTR/UPENDR.
REQ-002 SHALL have parameter UPSP_DATA_WIDTH, default 24, the width of one RGB pixel on every data path.
REQ-003 SHALL have parameter SRC_PIXELS, default 518400, the number of input pixels per frame.
REQ-004 SHALL have parameter DST_PIXELS, default 8294400, the number of output pixels per frame.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), the depth of the read-path FIFO.
REQ-006 SHALL have clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have UPSTR, input, CRF_DATA_WIDTH: bit0 is the start request; other bits are ignored.
REQ-009 SHALL have UPENDR, output, CRF_DATA_WIDTH: bit0 = done, bit1 = busy, all other bits 0.
REQ-010 SHALL have s_axis_tvalid/s_axis_tready/s_axis_tdata: input/output/input, 1/1/UPSP_DATA_WIDTH, the source pixel stream.
REQ-011 SHALL have upsp_ac_rready, input, 1 bit, and ac_upsp_rvalid, output, 1 bit: the pixel handshake to upsp.
REQ-012 SHALL have ac_upsp_rdata, output, UPSP_DATA_WIDTH: the pixel delivered to upsp.
REQ-013 SHALL have ac_upsp_wready, output, 1 bit, and upsp_ac_wvalid, input, 1 bit: the result handshake from upsp.
REQ-014 SHALL have upsp_ac_wdata, input, UPSP_DATA_WIDTH: the upsampled pixel from upsp.
REQ-015 SHALL have m_axis_tvalid/m_axis_tready/m_axis_tdata/m_axis_tlast: output/input/output/output, 1/1/UPSP_DATA_WIDTH/1, the result stream.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 IDLE -> RUN SHALL occur on a registered 0->1 edge of UPSTR[0]; the edge clears both counters and UPENDR[0].
REQ-018 A start edge in RUN SHALL be ignored.
REQ-019 RUN -> DONE SHALL occur on the cycle the DST_PIXELS-th m_axis handshake completes.
REQ-020 DONE SHALL last one cycle, set UPENDR[0]=1 and return to IDLE; UPENDR[0] holds until the next start edge.
REQ-021 UPENDR[1] SHALL be 1 exactly while state==RUN.
REQ-022 Read path SHALL be a first-word-fall-through FIFO of FIFO_DEPTH entries.
REQ-023 s_axis_tready SHALL equal (state==RUN) AND FIFO not full AND rd_cnt<SRC_PIXELS.
REQ-024 rd_cnt (32 bit) SHALL increment on each s_axis handshake.
REQ-025 A pixel accepted at cycle N SHALL appear on ac_upsp_rvalid/rdata at cycle N+1.
REQ-026 ac_upsp_rvalid SHALL be 1 iff the FIFO is non-empty; ac_upsp_rdata SHALL be the FIFO head.
REQ-027 The FIFO SHALL pop on ac_upsp_rvalid AND upsp_ac_rready.
REQ-028 When the FIFO is full, a pop SHALL be allowed but a push in the same cycle SHALL NOT (tready already low).
REQ-029 Simultaneous push and pop when not full SHALL keep the occupancy unchanged.
REQ-030 Write path SHALL be a one-entry output register.
REQ-031 ac_upsp_wready SHALL equal (state==RUN) AND (!m_axis_tvalid OR m_axis_tready).
REQ-032 On a write handshake the register SHALL load upsp_ac_wdata, set m_axis_tvalid, and set m_axis_tlast=1 iff wr_cnt==DST_PIXELS-1; wr_cnt then increments (32 bit).
REQ-033 m_axis_tvalid SHALL clear on an m_axis handshake with no new load in the same cycle.
REQ-034 m_axis_tdata and m_axis_tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-035 Counters SHALL never wrap within a frame; ready signals are gated at the limits.
REQ-036 Writes arriving after DST_PIXELS are reached SHALL stall (wready=0); FIFO contents remaining at DONE SHALL be flushed on the next start edge.

Reset
REQ-037 On rst_n=0, state SHALL be IDLE immediately (asynchronous), with FIFO empty and counters 0.
REQ-038 On rst_n=0, every output SHALL be 0: UPENDR, s_axis_tready, ac_upsp_rvalid, ac_upsp_rdata, ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast.
REQ-039 An UPSTR[0] level already 1 at reset release SHALL NOT start a frame; a fresh 0->1 edge is required.
REQ-040 Reset asserted mid-frame SHALL abort the frame; no partial done is reported.

Verification
REQ-041 SRC=4, DST=64, all ready=1, start -> 4 input handshakes, 64 output handshakes, tlast only on the 64th, UPENDR=0x1 after.
REQ-042 upsp_ac_rready=0 while 6 pixels are offered -> exactly 4 accepted, s_axis_tready=0, rvalid=1 with rdata equal to the 1st pixel.
REQ-043 m_axis_tready toggling 1010… -> no data lost or duplicated, tdata held stable while stalled, wready follows REQ-031.
REQ-044 Second start edge mid-frame -> ignored, counters unaffected; start after DONE -> UPENDR[0] clears, new frame runs.
REQ-045 rst_n pulsed low for 1 cycle mid-frame -> all outputs 0 immediately, IDLE, no start without a new UPSTR[0] edge.
REQ-046 Random valid/ready on all three ports, 200 frames -> scoreboard matches in-order data, counts exact.

Source files
------------

// File: rtl/ac_upsp_stream.sv
// Stream adapter between an AXI-Stream source/sink and the upsp core: FWFT read FIFO
// toward upsp, one-entry output register from upsp, and a start/busy/done frame FSM.
module ac_upsp_stream #(
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int UPSP_DATA_WIDTH = 24,
  parameter int SRC_PIXELS      = 518400,
  parameter int DST_PIXELS      = 8294400,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CRF_DATA_WIDTH-1:0]  UPSTR,
  output logic [CRF_DATA_WIDTH-1:0]  UPENDR,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [UPSP_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       upsp_ac_rready,
  output logic                       ac_upsp_rvalid,
  output logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
  output logic                       ac_upsp_wready,
  input  logic                       upsp_ac_wvalid,
  input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [UPSP_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic                       upstr_q, start_edge, flush;
  logic                       done_q, done_d;
  logic                       busy, s_rdy, w_rdy;
  logic [31:0]                rd_cnt_q, wr_cnt_q;
  logic [UPSP_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wptr_q, rptr_q;
  logic [AW:0]                occ_q;
  logic                       fifo_full, fifo_empty, push, pop;
  logic                       m_vld_q, m_last_q;
  logic [UPSP_DATA_WIDTH-1:0] m_data_q;
  logic                       w_hs, m_hs;
  logic                       unused_upstr;

  assign unused_upstr = ^UPSTR[CRF_DATA_WIDTH-1:1];

  // Reset value 1 so a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) upstr_q <= 1'b1;
    else        upstr_q <= UPSTR[0];

  assign start_edge = UPSTR[0] & ~upstr_q;
  assign flush      = (state_q == IDLE) & start_edge;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge)          state_d = RUN;
      RUN:     if (m_hs && m_last_q)    state_d = DONE;
      DONE:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    s_rdy  = busy & ~fifo_full & (rd_cnt_q < 32'(SRC_PIXELS));
    w_rdy  = busy & (~m_vld_q | m_axis_tready) & (wr_cnt_q < 32'(DST_PIXELS));
    done_d = done_q;
    if (flush)                                      done_d = 1'b0;
    else if (state_q == RUN && state_d == DONE)     done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;

  assign fifo_full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign push       = s_axis_tvalid & s_rdy;
  assign pop        = ~fifo_empty & upsp_ac_rready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == AW'(FIFO_DEPTH-1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == AW'(FIFO_DEPTH-1)) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end

  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= s_axis_tdata;

  assign w_hs = upsp_ac_wvalid & w_rdy;
  assign m_hs = m_vld_q & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (flush) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (push) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (w_hs) wr_cnt_q <= wr_cnt_q + 32'd1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
    end else if (w_hs) begin
      m_vld_q  <= 1'b1;
      m_last_q <= (wr_cnt_q == 32'(DST_PIXELS-1));
      m_data_q <= upsp_ac_wdata;
    end else if (m_hs) begin
      m_vld_q  <= 1'b0;
    end

  assign UPENDR         = {{(CRF_DATA_WIDTH-2){1'b0}}, busy, done_q};
  assign s_axis_tready  = s_rdy;
  assign ac_upsp_rvalid = ~fifo_empty;
  // Gate the head so rdata reads 0 whenever the FIFO is empty, including in reset.
  assign ac_upsp_rdata  = fifo_empty ? '0 : mem_q[rptr_q];
  assign ac_upsp_wready = w_rdy;
  assign m_axis_tvalid  = m_vld_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tlast   = m_last_q;
endmodule
